// File: rtl/div_issue_ctrl.sv
// Issue/collect controller around a fixed-latency, non-stallable pipelined divider.
// Optional overflow flagging is enabled by defining DIV_OVF_CHECK_EN.
module div_issue_ctrl #(
    parameter int unsigned K     = 32,
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [K+31:0]   in_x,
    input  logic [K-1:0]    in_d,
    input  logic [TW-1:0]   in_tag,
    output logic [K+31:0]   div_x,
    output logic [K-1:0]    div_d,
    input  logic [K-1:0]    div_q,
    input  logic [K-1:0]    div_r,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [K-1:0]    out_q,
    output logic [K-1:0]    out_r,
    output logic [TW-1:0]   out_tag,
    output logic            out_ovf
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(LAT + 1);
    localparam int unsigned SW = $clog2(DEPTH + LAT + 1);

    logic [LAT-1:0] sr_vld;
    logic [TW-1:0]  sr_tag [LAT];
    logic [K-1:0]   mem_q [DEPTH];
    logic [K-1:0]   mem_r [DEPTH];
    logic [TW-1:0]  mem_tag [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic [IW-1:0]  inflight;
    logic [SW-1:0]  occ;
    logic           acc;
    logic           push;
    logic           pop;
    logic [K-1:0]   push_q;
    logic [K-1:0]   push_r;

    assign div_x = in_x;
    assign div_d = in_d;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(LAT); i++) begin
            inflight = inflight + IW'(sr_vld[i]);
        end
    end

    // Every in-flight op already owns a FIFO slot, so the divider never needs to stall.
    assign occ       = SW'(inflight) + SW'(count);
    assign in_ready  = occ < SW'(DEPTH);
    assign acc       = in_valid && in_ready;
    assign out_valid = count != '0;
    assign push      = sr_vld[LAT-1];
    assign pop       = out_valid && out_ready;

`ifdef DIV_OVF_CHECK_EN
    logic             ovf_calc;
    logic [LAT-1:0]   sr_ovf;
    logic [DEPTH-1:0] mem_ovf;

    assign ovf_calc = in_x[K+31:K] >= in_d;
    assign push_q   = sr_ovf[LAT-1] ? {K{1'b1}} : div_q;
    assign push_r   = sr_ovf[LAT-1] ? '0 : div_r;
    assign out_ovf  = mem_ovf[rptr];

    always_ff @(posedge clk) begin
        sr_ovf[0] <= ovf_calc;
        for (int i = 1; i < int'(LAT); i++) begin
            sr_ovf[i] <= sr_ovf[i-1];
        end
        if (push) begin
            mem_ovf[wptr] <= sr_ovf[LAT-1];
        end
    end
`else
    assign push_q  = div_q;
    assign push_r  = div_r;
    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_vld <= '0;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
        end else begin
            sr_vld[0] <= acc;
            for (int i = 1; i < int'(LAT); i++) begin
                sr_vld[i] <= sr_vld[i-1];
            end
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity lives in sr_vld and count.
    always_ff @(posedge clk) begin
        sr_tag[0] <= in_tag;
        for (int i = 1; i < int'(LAT); i++) begin
            sr_tag[i] <= sr_tag[i-1];
        end
        if (push) begin
            mem_q[wptr]   <= push_q;
            mem_r[wptr]   <= push_r;
            mem_tag[wptr] <= sr_tag[LAT-1];
        end
    end

    assign out_q   = mem_q[rptr];
    assign out_r   = mem_r[rptr];
    assign out_tag = mem_tag[rptr];

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural two-stage divider model.
module tb_div_issue_ctrl;
    localparam int K = 32, LAT = 2, DEPTH = 4, TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [K+31:0] in_x, div_x;
    logic [K-1:0]  in_d, div_d, div_q, div_r;
    logic [TW-1:0] in_tag, out_tag;
    logic          out_valid, out_ready, out_ovf;
    logic [K-1:0]  out_q, out_r;

    always #5 clk = ~clk;

    div_issue_ctrl #(.K(K), .LAT(LAT), .DEPTH(DEPTH), .TW(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_d(in_d), .in_tag(in_tag), .div_x(div_x), .div_d(div_d),
        .div_q(div_q), .div_r(div_r), .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_tag(out_tag), .out_ovf(out_ovf)
    );

    // Divider: samples every edge, result visible two edges later.
    logic [K-1:0] s1_q, s1_r, s2_q, s2_r;
    always @(posedge clk) begin
        if (div_d == '0) begin
            s1_q <= '0;
            s1_r <= '0;
        end else begin
            s1_q <= K'(div_x / {32'd0, div_d});
            s1_r <= K'(div_x % {32'd0, div_d});
        end
        s2_q <= s1_q;
        s2_r <= s1_r;
    end
    assign div_q = s2_q;
    assign div_r = s2_r;

    typedef struct {
        logic [K-1:0]  q;
        logic [K-1:0]  r;
        logic [TW-1:0] tag;
        logic          ovf;
        int            edge_n;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [63:0] x, input logic [31:0] d,
                                   input logic [TW-1:0] tag);
        exp_t e;
        bit   ovf_on;
`ifdef DIV_OVF_CHECK_EN
        ovf_on = 1'b1;
`else
        ovf_on = 1'b0;
`endif
        e.tag = tag;
        e.edge_n = 0;
        if (ovf_on && (x[63:32] >= d)) begin
            e.q = '1;
            e.r = '0;
            e.ovf = 1'b1;
        end else begin
            e.q = (d == 0) ? '0 : K'(x / {32'd0, d});
            e.r = (d == 0) ? '0 : K'(x % {32'd0, d});
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Monitor: credit, visibility and in-order data checks.
    always @(negedge clk) begin
        bit exp_ov;
        chk("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
        exp_ov = (sb.size() > 0) && (sb[0].edge_n + LAT <= cyc);
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (out_valid && exp_ov) begin
            chk("out_q", 64'(out_q), 64'(sb[0].q));
            chk("out_r", 64'(out_r), 64'(sb[0].r));
            chk("out_tag", 64'(out_tag), 64'(sb[0].tag));
            chk("out_ovf", 64'(out_ovf), 64'(sb[0].ovf));
            if (out_ready) void'(sb.pop_front());
        end
    end

    task automatic issue(input logic v, input logic [63:0] x, input logic [31:0] d,
                         input logic [TW-1:0] tag, input logic ordy, output bit acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        in_x = x;
        in_d = d;
        in_tag = tag;
        out_ready = ordy;
        @(negedge clk);
        #1;
        acc = in_valid && in_ready && !rst;
        if (acc) begin
            e = model(x, d, tag);
            e.edge_n = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        bit a;
        for (int i = 0; i < n; i++) issue(1'b0, 64'd0, 32'd1, '0, ordy, a);
    endtask

    initial begin
        bit acc;
        int n_acc;
        logic [31:0] d, hi;
        rst = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_d = 32'd1;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Latency
        issue(1'b1, 64'd100, 32'd7, 4'd3, 1'b1, acc);
        chk("lat_accept", 64'(acc), 64'd1);
        idle(4, 1'b1);

        // Throughput
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 64'(1000 + i), 32'd3, TW'(i), 1'b1, acc);
            chk("tput_accept", 64'(acc), 64'd1);
        end
        idle(4, 1'b1);

        // Backpressure
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            issue(1'b1, 64'(2000 + i), 32'd9, TW'(i), 1'b0, acc);
            n_acc += int'(acc);
        end
        chk("bp_accepts", 64'(n_acc), 64'd4);
        idle(8, 1'b1);

        // Overflow cases
        issue(1'b1, 64'h0000_0005_0000_0000, 32'd5, 4'd7, 1'b1, acc);
        issue(1'b1, 64'h0000_0005_0000_0000, 32'd0, 4'd8, 1'b1, acc);
        idle(4, 1'b1);

        // Reset mid-flight
        issue(1'b1, 64'd77, 32'd4, 4'd1, 1'b1, acc);
        issue(1'b1, 64'd78, 32'd4, 4'd2, 1'b1, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(3, 1'b1);
        issue(1'b1, 64'd50, 32'd5, 4'd9, 1'b1, acc);
        chk("post_rst_accept", 64'(acc), 64'd1);
        idle(4, 1'b1);

        // Fill to 3, then push and pop together across the pointer wrap
        for (int i = 0; i < 3; i++) issue(1'b1, 64'(300 + i), 32'd7, TW'(i), 1'b0, acc);
        idle(2, 1'b0);
        for (int i = 0; i < 8; i++) issue(1'b1, 64'(400 + i), 32'd11, TW'(i + 3), 1'b1, acc);
        idle(6, 1'b1);

        // Random
        for (int i = 0; i < 400; i++) begin
            d = $urandom_range(32'hFFFF_FFFF, 32'd1);
            hi = ($urandom_range(9, 0) == 0) ? $urandom : ($urandom % d);
            issue(($urandom_range(3, 0) != 0), {hi, 32'($urandom)}, d, TW'($urandom),
                  ($urandom_range(2, 0) != 0), acc);
        end

        // Drain with a bounded wait
        for (int i = 0; i < 50 && sb.size() > 0; i++) idle(1, 1'b1);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
